// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the Mini-ALU comparator.
//   Mode encodings, FSM state type and a mode classification helper.
package cmp_pkg;

  localparam logic [1:0] CMP_BITLT = 2'b00;
  localparam logic [1:0] CMP_ULT   = 2'b01;
  localparam logic [1:0] CMP_SLT   = 2'b10;
  localparam logic [1:0] CMP_BITEQ = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude modes go through the serial RUN phase; bitwise modes do not.
  function automatic logic is_mag(input logic [1:0] m);
    return (m == CMP_ULT) || (m == CMP_SLT);
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// cmp_digit: combinational DIGIT-bit magnitude slice.
//   a_d, b_d : DIGIT-bit operand digits (MSB at index DIGIT-1)
//   d_lt     : a_d < b_d
//   d_gt     : a_d > b_d
//   Both 0 when the digits are equal.
module cmp_digit
  import cmp_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  output logic             d_lt,
  output logic             d_gt
);

  logic [DIGIT-1:0] blt, bgt;

  // Per-bit less-than / greater-than cells.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign blt[i] = ~a_d[i] &  b_d[i];
    assign bgt[i] =  a_d[i] & ~b_d[i];
  end

  // Scan LSB->MSB; any differing higher bit overrides, so the MSB-most
  // difference decides.
  always_comb begin
    d_lt = 1'b0;
    d_gt = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (blt[i] | bgt[i]) begin
        d_lt = blt[i];
        d_gt = bgt[i];
      end
    end
  end

endmodule

// File: rtl/cmp_unit.sv
// cmp_unit: handshaked comparator for the Mini-ALU.
//   Bitwise modes (BITLT, BITEQ) finish one cycle after accept.
//   Magnitude modes (ULT, SLT) scan the operands MSB-first, DIGIT bits per
//   cycle, for a fixed WIDTH/DIGIT cycles.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (ready only in IDLE)
//   a, b, mode           operands and mode (00 BITLT, 01 ULT, 10 SLT, 11 BITEQ)
//   out_valid/out_ready  result handshake, result held until out_ready
//   res                  result word (lt in bit 0 for magnitude modes)
//   lt, eq, gt           magnitude flags, 0 in bitwise modes
//   min_o, max_o         only when CMP_MINMAX_EN is defined
// Config macro: CMP_MINMAX_EN adds min/max selection outputs.
module cmp_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             lt,
  output logic             eq,
  output logic             gt
`ifdef CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("cmp_unit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb;          // operand windows, shifted left each RUN cycle
  logic             dec_lt, dec_gt;  // latched decision from earlier digits
  logic             d_lt, d_gt;
  logic             fin_lt, fin_gt;
  logic             last, accept, dec_any;

  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CW'(N - 1));

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d  (sa[WIDTH-1 -: DIGIT]),
    .b_d  (sb[WIDTH-1 -: DIGIT]),
    .d_lt (d_lt),
    .d_gt (d_gt)
  );

  // Once a digit differs the decision is frozen; later digits are ignored.
  assign dec_any = dec_lt | dec_gt;
  assign fin_lt  = dec_any ? dec_lt : d_lt;
  assign fin_gt  = dec_any ? dec_gt : d_gt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = is_mag(mode) ? RUN : DONE;
      RUN:  if (last)   nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      dec_lt <= 1'b0;
      dec_gt <= 1'b0;
      res    <= '0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          dec_lt <= 1'b0;
          dec_gt <= 1'b0;
          // SLT: flipping the sign bits maps two's complement onto unsigned order.
          sa <= {a[WIDTH-1] ^ (mode == CMP_SLT), a[WIDTH-2:0]};
          sb <= {b[WIDTH-1] ^ (mode == CMP_SLT), b[WIDTH-2:0]};
          if (!is_mag(mode)) begin
            res <= (mode == CMP_BITEQ) ? ~(a ^ b) : (~a & b);
            lt  <= 1'b0;
            eq  <= 1'b0;
            gt  <= 1'b0;
          end
        end
        RUN: begin
          cnt    <= cnt + CW'(1);
          sa     <= sa << DIGIT;
          sb     <= sb << DIGIT;
          dec_lt <= fin_lt;
          dec_gt <= fin_gt;
          if (last) begin
            lt  <= fin_lt;
            gt  <= fin_gt;
            eq  <= ~(fin_lt | fin_gt);
            res <= {{(WIDTH-1){1'b0}}, fin_lt};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] a_q, b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      min_o <= '0;
      max_o <= '0;
    end else begin
      if (state == IDLE && accept) begin
        a_q <= a;
        b_q <= b;
        if (!is_mag(mode)) begin
          min_o <= a;
          max_o <= a;
        end
      end
      // Equal operands take the b/a branch, which is a either way.
      if (state == RUN && last) begin
        min_o <= fin_lt ? a_q : b_q;
        max_o <= fin_lt ? b_q : a_q;
      end
    end
  end
`endif

endmodule
